// File: rtl/param_reg_bank_pkg.sv
// Shared definitions for the parametrised register bank.
//   REG_WIDTH   : default register width in bits
//   RB_LOCK_BIT : bit position of the lock flag inside the LOCK word
//   rb_state_e  : request/response FSM states
//   idx_width   : index width for a given register count (at least 1 bit)
package param_reg_bank_pkg;

  localparam int unsigned REG_WIDTH   = 32;
  localparam int unsigned RB_LOCK_BIT = 0;

  typedef enum logic [0:0] {
    RB_IDLE,
    RB_RESP
  } rb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_reg_bank_if.sv
// Request/response bus of the register bank.
//   master : drives req_valid/req_write/req_addr/req_wdata/req_wstrb and rsp_ready
//   slave  : drives req_ready and rsp_valid/rsp_rdata/rsp_err
// A request transfers on req_valid & req_ready; a response on rsp_valid & rsp_ready.
interface param_reg_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/param_reg_bank_slot.sv
// One register of the bank: byte-strobed bus write merged with a full-word hardware write.
//   clk, rst_n   : clock, asynchronous active-low reset (register clears to 0)
//   bus_we_i     : bus write enable for this slot (already decoded and error-free)
//   bus_wstrb_i  : bus byte enables
//   bus_wdata_i  : bus write data
//   hw_we_i      : hardware write enable for this slot
//   hw_wdata_i   : hardware write data
//   q_o          : current register value
module param_reg_bank_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_we_i,
  input  logic [DATA_W/8-1:0] bus_wstrb_i,
  input  logic [DATA_W-1:0]   bus_wdata_i,
  input  logic                hw_we_i,
  input  logic [DATA_W-1:0]   hw_wdata_i,
  output logic [DATA_W-1:0]   q_o
);

  logic [DATA_W-1:0] q_d, q_q;

  // Bus-strobed bytes win over the hardware word; unstrobed bytes take hw data if present.
  always_comb begin
    q_d = q_q;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      if (bus_we_i && bus_wstrb_i[b]) begin
        q_d[b*8 +: 8] = bus_wdata_i[b*8 +: 8];
      end else if (hw_we_i) begin
        q_d[b*8 +: 8] = hw_wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/param_reg_bank.sv
// Parametrised register bank with a single-outstanding valid/ready request/response bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bus (slave side)
//   hw_we      : hardware write strobe, full word into register hw_idx
//   hw_idx     : hardware write target; out-of-range indices are ignored
//   hw_wdata   : hardware write data
//   regs_q     : flattened register contents, register i at [i*DATA_W +: DATA_W]
// Optional feature macro: REG_LOCK_EN adds a sticky LOCK word at byte address NUM_REGS*4 that,
// once set by the bus, rejects bus writes to all registers until reset.
module param_reg_bank
  import param_reg_bank_pkg::*;
#(
  parameter int unsigned          NUM_REGS = 7,
  parameter int unsigned          DATA_W   = REG_WIDTH,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  localparam int unsigned         IdxW     = idx_width(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  param_reg_bank_if.slave              bus,
  input  logic                         hw_we,
  input  logic [IdxW-1:0]              hw_idx,
  input  logic [DATA_W-1:0]            hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q
);

  if (ADDR_W < IdxW + 2) begin : g_bad_addr_w
    $error("param_reg_bank: ADDR_W too small to address NUM_REGS words");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("param_reg_bank: DATA_W must be a multiple of 8");
  end

  rb_state_e state_d, state_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] reg_words [NUM_REGS];

  // Address decode
  logic [ADDR_W-1:0] word_idx;
  logic              aligned, in_range;
  logic [IdxW-1:0]   slot_idx;
  logic              accept, locked;
  logic              dec_err, dec_wr_ok;
  logic [DATA_W-1:0] dec_rdata;

  assign word_idx = bus.req_addr >> 2;
  assign aligned  = (bus.req_addr[1:0] == 2'b00);
  assign in_range = (word_idx < ADDR_W'(NUM_REGS));
  assign slot_idx = word_idx[IdxW-1:0];
  assign accept   = bus.req_valid && (state_q == RB_IDLE);

`ifdef REG_LOCK_EN
  logic lock_q, lock_set, lock_hit;

  assign lock_hit = aligned && (word_idx == ADDR_W'(NUM_REGS));
  assign locked   = lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    dec_err   = 1'b1;
    dec_wr_ok = 1'b0;
    dec_rdata = '0;
`ifdef REG_LOCK_EN
    lock_set  = 1'b0;
`endif
    if (aligned && in_range) begin
      if (bus.req_write) begin
        dec_err   = RO_MASK[slot_idx] || locked;
        dec_wr_ok = !dec_err;
      end else begin
        dec_err   = 1'b0;
        dec_rdata = reg_words[slot_idx];
      end
`ifdef REG_LOCK_EN
    end else if (lock_hit) begin
      dec_err = 1'b0;
      if (bus.req_write) begin
        // Only an accepted write may set the lock; setting it again is harmless.
        lock_set = accept && bus.req_wstrb[RB_LOCK_BIT / 8] && bus.req_wdata[RB_LOCK_BIT];
      end else begin
        dec_rdata[RB_LOCK_BIT] = lock_q;
      end
`endif
    end
  end

  // Request/response FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RB_IDLE: if (bus.req_valid) state_d = RB_RESP;
      RB_RESP: if (bus.rsp_ready) state_d = RB_IDLE;
      default: state_d = RB_IDLE;
    endcase
  end

  // Response is captured at the accept edge, so reads see the value before any
  // same-edge hardware write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RB_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_rdata_q <= dec_rdata;
        rsp_err_q   <= dec_err;
      end
    end
  end

  assign bus.req_ready = (state_q == RB_IDLE);
  assign bus.rsp_valid = (state_q == RB_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Register slots
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    logic slot_bus_we, slot_hw_we;

    assign slot_bus_we = accept && bus.req_write && dec_wr_ok && (slot_idx == IdxW'(i));
    assign slot_hw_we  = hw_we && (hw_idx == IdxW'(i));

    param_reg_bank_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_we_i    (slot_bus_we),
      .bus_wstrb_i (bus.req_wstrb),
      .bus_wdata_i (bus.req_wdata),
      .hw_we_i     (slot_hw_we),
      .hw_wdata_i  (hw_wdata),
      .q_o         (reg_words[i])
    );

    assign regs_q[i*DATA_W +: DATA_W] = reg_words[i];
  end

endmodule
